// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO with occupancy count,
// almost-full/almost-empty flags and a clearable high-water mark.
module stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    input  logic [CNT_W-1:0] af_thresh,
    input  logic [CNT_W-1:0] ae_thresh,
    output logic [CNT_W-1:0] count,
    output logic             a_full,
    output logic             a_empty,
    input  logic             wm_clear,
    output logic [CNT_W-1:0] watermark
);
    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wm_q, wm_d;
    logic             push, pop;

    // Ready depends only on the registered count: a full FIFO never accepts,
    // even when a pop happens in the same cycle.
    assign s_ready = (count_q < FULL_CNT);
    assign m_valid = (count_q != '0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    assign m_data    = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign watermark = wm_q;
    assign a_full    = (count_q >= af_thresh);
    assign a_empty   = (count_q <= ae_thresh);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // High-water mark tracks the next count so a clear reloads the live level.
    always_comb begin
        wm_d = wm_q;
        if (wm_clear) begin
            wm_d = count_d;
        end else if (count_d > wm_q) begin
            wm_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wm_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wm_q     <= wm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and randomized checks of stream_fifo against a queue-based reference.
module tb_stream_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] af_thresh;
    logic [CNT_W-1:0] ae_thresh;
    logic [CNT_W-1:0] count;
    logic             a_full;
    logic             a_empty;
    logic             wm_clear;
    logic [CNT_W-1:0] watermark;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] q[$];
    int               wm_m = 0;

    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .af_thresh (af_thresh),
        .ae_thresh (ae_thresh),
        .count     (count),
        .a_full    (a_full),
        .a_empty   (a_empty),
        .wm_clear  (wm_clear),
        .watermark (watermark)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count",     64'(count),     64'(n));
        check("watermark", 64'(watermark), 64'(wm_m));
        check("s_ready",   64'(s_ready),   64'(n < DEPTH));
        check("m_valid",   64'(m_valid),   64'(n != 0));
        check("a_full",    64'(a_full),    64'(n >= int'(af_thresh)));
        check("a_empty",   64'(a_empty),   64'(n <= int'(ae_thresh)));
        if (n > 0) check("m_data", 64'(m_data), 64'(q[0]));
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, compare shortly after.
    task automatic step(input bit sv, input logic [WIDTH-1:0] sd, input bit mr,
                        input bit fl, input bit wc);
        bit do_push, do_pop;
        @(negedge clk);
        s_valid  = sv;
        s_data   = sd;
        m_ready  = mr;
        flush    = fl;
        wm_clear = wc;
        @(posedge clk);
        do_push = sv && (q.size() < DEPTH);
        do_pop  = mr && (q.size() > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(sd);
        end
        if (wc) wm_m = q.size();
        else if (q.size() > wm_m) wm_m = q.size();
        #1;
        check_all();
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        wm_clear  = 1'b0;
        af_thresh = 5'd0;
        ae_thresh = 5'd2;
        #3;
        check("reset_a_full_thresh0", 64'(a_full), 64'd1);
        check_all();
        af_thresh = 5'd12;
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;

        // Single word into empty FIFO, then pop it.
        step(1, 32'hA5, 0, 0, 0);
        check("fwft_data", 64'(m_data), 64'hA5);
        step(0, 32'h0, 1, 0, 0);
        check("fwft_empty", 64'(m_valid), 64'd0);

        // Fill to full with 1..16; flags checked each cycle by the model.
        for (int i = 1; i <= DEPTH; i++) step(1, WIDTH'(i), 0, 0, 0);
        check("full_count", 64'(count), 64'd16);
        check("full_wm", 64'(watermark), 64'd16);
        step(1, 32'h99, 0, 0, 0);
        check("full_reject_head", 64'(m_data), 64'd1);
        // Pop while full: push must not pass through.
        step(1, 32'h77, 1, 0, 0);
        check("full_pop_no_pass", 64'(count), 64'd15);

        // Drain to 8, then stream 40 cycles across pointer wrap.
        for (int i = 0; i < 7; i++) step(0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 32'h1000 + i, 1, 0, 0);
        check("stream_count", 64'(count), 64'd8);

        // Flush together with wm_clear zeros both.
        step(0, 32'h0, 0, 1, 1);
        check("flush_clear_wm", 64'(watermark), 64'd0);

        // Count to 10, then flush with push and pop asserted.
        for (int i = 0; i < 10; i++) step(1, 32'h200 + i, 0, 0, 0);
        step(1, 32'hDEAD, 1, 1, 0);
        check("flush_wm_kept", 64'(watermark), 64'd10);
        step(0, 32'h0, 0, 0, 1);
        check("wm_clear", 64'(watermark), 64'd0);

        // Randomized traffic with occasional flush and watermark clears.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0);
        end
        af_thresh = 5'd5;
        ae_thresh = 5'd9;
        for (int i = 0; i < 150; i++) begin
            step($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 1) != 0,
                 1'b0, $urandom_range(0, 30) == 0);
        end

        // Asynchronous reset at count 5 aborts everything.
        step(0, 32'h0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 32'h300 + i, 0, 0, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        q.delete();
        wm_m = 0;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        step(1, 32'h5EED, 0, 0, 0);
        check("post_reset_data", 64'(m_data), 64'h5EED);
        step(0, 32'h0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >=4.
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, width of count/threshold/watermark ports.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous clear of contents.
REQ-007 SHALL have port s_valid  input  1  write request.
REQ-008 SHALL have port s_ready  output  1  FIFO can accept write.
REQ-009 SHALL have port s_data  input  WIDTH  write data.
REQ-010 SHALL have port m_valid  output  1  head entry available.
REQ-011 SHALL have port m_ready  input  1  consumer takes head.
REQ-012 SHALL have port m_data  output  WIDTH  head entry data.
REQ-013 SHALL have port af_thresh  input  CNT_W  almost-full level, quasi-static.
REQ-014 SHALL have port ae_thresh  input  CNT_W  almost-empty level, quasi-static.
REQ-015 SHALL have port count  output  CNT_W  current occupancy.
REQ-016 SHALL have port a_full  output  1  count >= af_thresh.
REQ-017 SHALL have port a_empty  output  1  count <= ae_thresh.
REQ-018 SHALL have port wm_clear  input  1  clear high-water mark.
REQ-019 SHALL have port watermark  output  CNT_W  max occupancy since last clear.

Function
REQ-020 SHALL define push = s_valid & s_ready and pop = m_valid & m_ready; only these events change state.
REQ-021 SHALL drive s_ready = (count < DEPTH); no write pass-through when full, even if a pop occurs in the same cycle.
REQ-022 SHALL drive m_valid = (count != 0); first-word-fall-through: write into empty FIFO gives m_valid=1 on the next cycle, with m_data equal to that word.
REQ-023 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-024 SHALL keep read/write pointers $clog2(DEPTH) bits wide, wrapping DEPTH-1 -> 0 without gaps.
REQ-025 SHALL update count as count + push - pop each cycle; simultaneous push and pop leave count unchanged and preserve order.
REQ-026 SHALL compute a_full and a_empty combinationally from the registered count; af_thresh=0 gives a_full=1 constantly.
REQ-027 SHALL update watermark to max(watermark, next count) each cycle; wm_clear loads the next count value.
REQ-028 SHALL, on flush=1, set pointers and count to 0 on the next edge, ignoring push/pop in that cycle; s_ready stays combinational from count.
REQ-029 SHALL leave storage contents undefined after flush; m_data is don't-care while m_valid=0.
REQ-030 SHALL make flush and wm_clear in the same cycle yield count=0 and watermark=0.

Reset
REQ-031 SHALL, on rstn low, asynchronously clear pointers, count and watermark to 0, giving s_ready=1, m_valid=0, a_empty=1, and a_full=(af_thresh==0).
REQ-032 SHALL not require storage array reset; m_data is don't-care until the first write.
REQ-033 SHALL treat reset mid-transfer as a complete abort; no pre-reset data reappears.

Verification
REQ-034 SHALL cover: DEPTH=16, write 16 words 0x1..0x10 with m_ready=0 -> s_ready=0 after 16th, count=16, watermark=16; a 17th s_valid is not accepted.
REQ-035 SHALL cover: single write 0xA5 into empty -> next cycle m_valid=1, m_data=0xA5; pop -> m_valid=0, count=0.
REQ-036 SHALL cover: count=8, s_valid=m_ready=1 for 40 cycles with incrementing data -> count stays 8, output order strictly incrementing across pointer wrap.
REQ-037 SHALL cover: af_thresh=12, ae_thresh=2; fill 0->16 -> a_empty deasserts at count=3, a_full asserts at count=12.
REQ-038 SHALL cover: count=10, flush with push and pop -> next cycle count=0, m_valid=0, watermark stays 10; wm_clear -> watermark=0.
REQ-039 SHALL cover: rstn pulsed low at count=5 -> immediately count=0, m_valid=0, s_ready=1, watermark=0.
